// File: rtl/vga_layer_scheduler.sv
// Layer scheduler for a three-layer text overlay: debounced switch requests,
// frame-aligned manual/auto-rotate layer selection and a registered colour mux.
module vga_layer_scheduler #(
    parameter int         DB_CYCLES  = 16,
    parameter int         ROT_FRAMES = 60,
    parameter logic [2:0] BG_COLOR   = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       swt1,
    input  logic       swt2,
    input  logic       swt3,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic [2:0] text_on,
    input  logic [2:0] rgb_text_j,
    input  logic [2:0] rgb_text_d,
    input  logic [2:0] rgb_text_m,
    output logic [2:0] rgb_text,
    output logic [1:0] layer_sel,
    output logic [1:0] mode,
    output logic       frame_tick
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
    localparam logic [7:0]    ROT_LAST = 8'(ROT_FRAMES - 1);

    localparam logic [1:0] BLANK  = 2'd0;
    localparam logic [1:0] MANUAL = 2'd1;
    localparam logic [1:0] ROTATE = 2'd2;

    logic [2:0]          sync1, sync2, db_level;
    logic [2:0][CW-1:0]  db_cnt;
    logic                armed, frame_start;
    logic [7:0]          rot_cnt;
    logic                req_vld;
    logic [1:0]          req_layer;
    logic [2:0]          sel_rgb;
    logic                origin;

    assign origin     = (pixel_x == 10'd0) && (pixel_y == 10'd0);
    assign frame_tick = frame_start;

    // Switch synchronisers and per-switch debounce counters
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            db_level <= '0;
            db_cnt   <= '0;
        end else begin
            sync1 <= {swt3, swt2, swt1};
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]   <= '0;
                    db_level[i] <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // armed means the origin was absent last cycle, so a frame start needs a
    // genuine 0->1 transition of the origin condition, also right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            armed       <= ~origin;
            frame_start <= origin & armed;
        end
    end

    always_comb begin
        req_vld   = |db_level;
        req_layer = 2'd2;
        if (db_level[0])      req_layer = 2'd0;
        else if (db_level[1]) req_layer = 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode      <= BLANK;
            layer_sel <= 2'd0;
            rot_cnt   <= '0;
        end else if (frame_start) begin
            if (req_vld) begin
                mode      <= MANUAL;
                layer_sel <= req_layer;
            end else begin
                case (mode)
                    BLANK: begin
                        mode      <= ROTATE;
                        layer_sel <= 2'd0;
                        rot_cnt   <= '0;
                    end
                    MANUAL: begin
                        mode    <= ROTATE;
                        rot_cnt <= '0;
                    end
                    default: begin
                        if (rot_cnt == ROT_LAST) begin
                            rot_cnt   <= '0;
                            layer_sel <= (layer_sel == 2'd2) ? 2'd0 : layer_sel + 2'd1;
                        end else begin
                            rot_cnt <= rot_cnt + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        case (layer_sel)
            2'd0:    sel_rgb = rgb_text_j;
            2'd1:    sel_rgb = rgb_text_d;
            default: sel_rgb = rgb_text_m;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)                          rgb_text <= 3'b000;
        else if (mode == BLANK || !video_on) rgb_text <= 3'b000;
        else if (text_on[layer_sel])        rgb_text <= sel_rgb;
        else                                rgb_text <= BG_COLOR;
    end
endmodule

// File: tb/tb_vga_layer_scheduler.sv
// Directed bench for vga_layer_scheduler with short debounce and rotate periods.
module tb_vga_layer_scheduler;
    logic       clk = 1'b0;
    logic       reset;
    logic       swt1, swt2, swt3;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on;
    logic [2:0] text_on;
    logic [2:0] rgb_text_j, rgb_text_d, rgb_text_m;
    logic [2:0] rgb_text;
    logic [1:0] layer_sel, mode;
    logic       frame_tick;

    int n_vec = 0;
    int n_err = 0;
    int ft_count = 0;

    localparam logic [2:0] BG = 3'b011;

    vga_layer_scheduler #(.DB_CYCLES(4), .ROT_FRAMES(2), .BG_COLOR(BG)) dut (
        .clk(clk), .reset(reset),
        .swt1(swt1), .swt2(swt2), .swt3(swt3),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .text_on(text_on),
        .rgb_text_j(rgb_text_j), .rgb_text_d(rgb_text_d), .rgb_text_m(rgb_text_m),
        .rgb_text(rgb_text), .layer_sel(layer_sel), .mode(mode), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (frame_tick) ft_count++;
        end
    endtask

    // One-cycle origin pulse; on return the FSM has acted on the frame start.
    task automatic do_frame(input string tag);
        pixel_x = 10'd0; pixel_y = 10'd0;
        tick(1);
        chk({tag, "_tick"}, frame_tick, 1'b1);
        pixel_x = 10'd1;
        tick(1);
        chk({tag, "_tick_off"}, frame_tick, 1'b0);
    endtask

    logic [1:0] rot_exp [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};

    initial begin
        reset = 1'b1;
        {swt1, swt2, swt3} = 3'b000;
        pixel_x = 10'd5; pixel_y = 10'd5;
        video_on = 1'b1; text_on = 3'b111;
        rgb_text_j = 3'b110; rgb_text_d = 3'b101; rgb_text_m = 3'b001;
        tick(2);
        chk("rst_rgb", rgb_text, 3'b000);
        chk("rst_layer", layer_sel, 2'd0);
        chk("rst_mode", mode, 2'd0);
        chk("rst_tick", frame_tick, 1'b0);
        reset = 1'b0;
        tick(2);
        chk("blank_rgb", rgb_text, 3'b000);

        // Auto-rotate from reset, no switches
        ft_count = 0;
        for (int f = 0; f < 7; f++) begin
            do_frame("rot");
            chk("rot_mode", mode, 2'd2);
            chk("rot_layer", layer_sel, rot_exp[f]);
            tick(3);
        end
        chk("rot_tick_count", ft_count, 7);

        // Short glitch on swt2 must not debounce
        swt2 = 1'b1; tick(3); swt2 = 1'b0;
        tick(10);
        chk("glitch_db", dut.db_level[1], 1'b0);
        chk("glitch_layer", layer_sel, 2'd0);

        // Held swt2: debounced on the 4th synchronised sample (6th edge)
        swt2 = 1'b1;
        tick(5);
        chk("db_early", dut.db_level[1], 1'b0);
        tick(1);
        chk("db_set", dut.db_level[1], 1'b1);
        tick(3);
        chk("db_no_midframe", layer_sel, 2'd0);
        do_frame("man_d");
        chk("man_d_mode", mode, 2'd1);
        chk("man_d_layer", layer_sel, 2'd1);

        // Colour mux on layer D
        video_on = 1'b1; text_on = 3'b010;
        tick(1);
        chk("rgb_text_d", rgb_text, 3'b101);
        text_on = 3'b001;
        tick(1);
        chk("rgb_bg", rgb_text, BG);
        video_on = 1'b0;
        tick(1);
        chk("rgb_blank_video", rgb_text, 3'b000);
        video_on = 1'b1;

        // Priority swt1 over swt3, then fall back
        swt2 = 1'b0; swt1 = 1'b1; swt3 = 1'b1;
        tick(10);
        do_frame("prio");
        chk("prio_layer", layer_sel, 2'd0);
        swt1 = 1'b0;
        tick(10);
        chk("prio_hold", layer_sel, 2'd0);
        do_frame("drop1");
        chk("drop1_layer", layer_sel, 2'd2);
        chk("drop1_mode", mode, 2'd1);
        swt3 = 1'b0;
        tick(10);
        do_frame("drop3");
        chk("drop3_mode", mode, 2'd2);
        chk("drop3_layer", layer_sel, 2'd2);

        // Debounce completing on the frame-start edge uses the old request
        swt1 = 1'b1;
        tick(4);
        pixel_x = 10'd0; pixel_y = 10'd0;
        tick(1);
        chk("race_tick", frame_tick, 1'b1);
        pixel_x = 10'd1;
        tick(1);
        chk("race_db", dut.db_level[0], 1'b1);
        chk("race_mode", mode, 2'd2);
        chk("race_layer", layer_sel, 2'd2);
        tick(2);
        do_frame("race_next");
        chk("race_next_mode", mode, 2'd1);
        chk("race_next_layer", layer_sel, 2'd0);
        swt1 = 1'b0;
        tick(10);

        // Origin held for two cycles gives one tick
        ft_count = 0;
        pixel_x = 10'd0; pixel_y = 10'd0;
        tick(1);
        chk("hold_tick1", frame_tick, 1'b1);
        tick(1);
        chk("hold_tick2", frame_tick, 1'b0);
        pixel_x = 10'd1;
        tick(2);
        chk("hold_count", ft_count, 1);

        // Reset during the origin cycle
        pixel_x = 10'd0; pixel_y = 10'd0;
        reset = 1'b1;
        tick(1);
        chk("mid_rst_mode", mode, 2'd0);
        chk("mid_rst_layer", layer_sel, 2'd0);
        chk("mid_rst_rgb", rgb_text, 3'b000);
        chk("mid_rst_tick", frame_tick, 1'b0);
        reset = 1'b0;
        ft_count = 0;
        tick(3);
        chk("post_rst_no_tick", ft_count, 0);
        pixel_x = 10'd1;
        tick(1);
        chk("post_rst_still_blank", mode, 2'd0);
        pixel_x = 10'd0;
        tick(1);
        chk("post_rst_tick", frame_tick, 1'b1);
        pixel_x = 10'd1;
        tick(1);
        chk("post_rst_rotate", mode, 2'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
